// File: rtl/fire_ofm_writer_pkg.sv
`default_nettype none
// ============================================================================
//  Module : fire_ofm_writer_pkg
//  Brief  : Shared FSM state encoding and pixel-count helper for the
//           layer output-feature-map writers.
//  Rev    : 1.0  initial release
// ============================================================================
package fire_ofm_writer_pkg;

  // Writer FSM state encoding
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ARMED = 2'd1;
  localparam logic [1:0] c_ST_WRITE = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  // Pixels per channel of a square WOUT x WOUT feature map
  function automatic int pix_count(input int wout);
    return wout * wout;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fire_ofm_writer.sv
`default_nettype none
// ============================================================================
//  Module : fire_ofm_writer
//  Brief  : Captures a DSP_NO-wide conv-layer output vector on each sample
//           pulse and writes it channel-major into the next layer's feature
//           map RAM, one word per cycle. Pulses ram_feedback once every
//           pixel of the layer has been written.
//  Rev    : 1.0  initial release
// ============================================================================
module fire_ofm_writer
  import fire_ofm_writer_pkg::*;
#(
  parameter int WOUT   = 32,
  parameter int DSP_NO = 32,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DSP_NO * WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_en,
  input  logic              ofm_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              ram_feedback,
  output logic              busy,
  output logic              overflow
);

  localparam int c_PIX   = pix_count(WOUT);
  localparam int c_PIX_W = (c_PIX > 1) ? $clog2(c_PIX) : 1;
  localparam int c_CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(c_PIX - 1);
  localparam logic [c_CH_W-1:0]  c_CH_LAST  = c_CH_W'(DSP_NO - 1);
  localparam logic [ADDR_W-1:0]  c_CH_STEP  = ADDR_W'(c_PIX);

  logic [1:0]         state_q, state_d;
  logic [c_PIX_W-1:0] pix_q, pix_d;
  logic [c_CH_W-1:0]  ch_q, ch_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               fb_q, fb_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   buf_q [0:DSP_NO-1];
  logic               capture;

  // Next-state logic: arm, capture, serialize channel by channel, finish
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    addr_d  = addr_q;
    fb_d    = 1'b0;
    // A sample landing while serializing is dropped and flagged for good
    ovf_d   = ovf_q | (ofm_sample & (state_q == c_ST_WRITE));
    capture = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        if (layer_en) begin
          state_d = c_ST_ARMED;
        end
      end

      c_ST_ARMED: begin
        if (!layer_en) begin
          state_d = c_ST_IDLE;
          pix_d   = '0;
          ch_d    = '0;
        end else if (ofm_sample) begin
          capture = 1'b1;
          state_d = c_ST_WRITE;
          ch_d    = '0;
          // Channel 0 of this pixel lives at address pix
          addr_d  = ADDR_W'(pix_q);
        end
      end

      c_ST_WRITE: begin
        if (!layer_en) begin
          state_d = c_ST_IDLE;
          pix_d   = '0;
          ch_d    = '0;
        end else if (ch_q == c_CH_LAST) begin
          ch_d = '0;
          if (pix_q == c_PIX_LAST) begin
            state_d = c_ST_DONE;
            fb_d    = 1'b1;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = c_ST_ARMED;
          end
        end else begin
          ch_d   = ch_q + 1'b1;
          // Stride to the same pixel of the next channel plane
          addr_d = addr_q + c_CH_STEP;
        end
      end

      c_ST_DONE: begin
        if (!layer_en) begin
          state_d = c_ST_IDLE;
          pix_d   = '0;
          ch_d    = '0;
        end
      end

      default: begin
        state_d = c_ST_IDLE;
        pix_d   = '0;
        ch_d    = '0;
      end
    endcase
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= c_ST_IDLE;
      pix_q   <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
      fb_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      ch_q    <= ch_d;
      addr_q  <= addr_d;
      fb_q    <= fb_d;
      ovf_q   <= ovf_d;
    end
  end

  // Capture buffer: data-path only, contents are don't-care after reset
  generate
    for (genvar g = 0; g < DSP_NO; g++) begin : g_buf
      always_ff @(posedge clk) begin
        if (capture) begin
          buf_q[g] <= ofm[g];
        end
      end
    end
  endgenerate

  // Writes stop in the same cycle the layer is disarmed
  assign ram_we       = (state_q == c_ST_WRITE) & layer_en;
  assign ram_addr     = addr_q;
  assign ram_wdata    = ram_we ? buf_q[ch_q] : '0;
  assign ram_feedback = fb_q;
  assign busy         = (state_q == c_ST_WRITE);
  assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fire_ofm_writer.sv
`default_nettype none
// ============================================================================
//  Module : tb_fire_ofm_writer
//  Brief  : Scoreboard bench for fire_ofm_writer: a small 4x4x4 instance for
//           functional scenarios and a default-sized instance for a full layer.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_fire_ofm_writer;

  localparam int SW = 4;
  localparam int SD = 4;
  localparam int SA = 6;
  localparam int BW = 32;
  localparam int BD = 32;
  localparam int BA = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // small instance
  logic          en_s, smp_s;
  logic [15:0]   ofm_s [0:SD-1];
  logic          we_s, fb_s, busy_s, ovf_s;
  logic [SA-1:0] addr_s;
  logic [15:0]   wd_s;

  // default-sized instance
  logic          en_b, smp_b;
  logic [15:0]   ofm_b [0:BD-1];
  logic          we_b, fb_b, busy_b, ovf_b;
  logic [BA-1:0] addr_b;
  logic [15:0]   wd_b;

  fire_ofm_writer #(.WOUT(SW), .DSP_NO(SD), .WIDTH(16), .ADDR_W(SA)) u_small (
    .clk(clk), .rst(rst), .layer_en(en_s), .ofm_sample(smp_s), .ofm(ofm_s),
    .ram_we(we_s), .ram_addr(addr_s), .ram_wdata(wd_s),
    .ram_feedback(fb_s), .busy(busy_s), .overflow(ovf_s)
  );

  fire_ofm_writer u_big (
    .clk(clk), .rst(rst), .layer_en(en_b), .ofm_sample(smp_b), .ofm(ofm_b),
    .ram_we(we_b), .ram_addr(addr_b), .ram_wdata(wd_b),
    .ram_feedback(fb_b), .busy(busy_b), .overflow(ovf_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [SA+15:0] q_s [$];
  logic [BA+15:0] q_b [$];
  int             wcount [0:63];
  int             fb_cnt = 0;
  int             fb_b_cnt = 0;
  logic           prev_we_s = 1'b0;
  logic [SA-1:0]  prev_addr_s = '0;
  logic           prev_we_b = 1'b0;
  logic [BA-1:0]  prev_addr_b = '0;
  logic [BA-1:0]  last_addr_b = '0;
  int             exp_pix = 0;

  // small-instance scoreboard monitor
  always @(negedge clk) begin
    logic [SA+15:0] e;
    if (we_s === 1'b1) begin
      n_cmp++;
      wcount[int'(addr_s)]++;
      if (q_s.size() == 0) begin
        n_bad++;
        $display("FAIL small_write unexpected: addr=%0d data=%h required=no write", addr_s, wd_s);
      end else begin
        e = q_s.pop_front();
        if ({addr_s, wd_s} !== e)
          begin
            n_bad++;
            $display("FAIL small_write: addr=%0d data=%h required addr=%0d data=%h",
                     addr_s, wd_s, e[SA+15:16], e[15:0]);
          end
      end
    end
    if (fb_s === 1'b1) begin
      fb_cnt++;
      n_cmp++;
      if (!(prev_we_s === 1'b1 && prev_addr_s === 6'd63)) begin
        n_bad++;
        $display("FAIL small_feedback_timing: prev_we=%b prev_addr=%0d required prev write to 63",
                 prev_we_s, prev_addr_s);
      end
    end
    prev_we_s   = we_s;
    prev_addr_s = addr_s;
  end

  // default-instance scoreboard monitor
  always @(negedge clk) begin
    logic [BA+15:0] e;
    if (we_b === 1'b1) begin
      n_cmp++;
      last_addr_b = addr_b;
      if (q_b.size() == 0) begin
        n_bad++;
        $display("FAIL big_write unexpected: addr=%0d data=%h required=no write", addr_b, wd_b);
      end else begin
        e = q_b.pop_front();
        if ({addr_b, wd_b} !== e) begin
          n_bad++;
          $display("FAIL big_write: addr=%0d data=%h required addr=%0d data=%h",
                   addr_b, wd_b, e[BA+15:16], e[15:0]);
        end
      end
    end
    if (fb_b === 1'b1) begin
      fb_b_cnt++;
      n_cmp++;
      if (!(prev_we_b === 1'b1 && prev_addr_b === 15'd32767)) begin
        n_bad++;
        $display("FAIL big_feedback_timing: prev_we=%b prev_addr=%0d required prev write to 32767",
                 prev_we_b, prev_addr_b);
      end
    end
    prev_we_b   = we_b;
    prev_addr_b = addr_b;
  end

  // Drive one sample into the small instance; the first nwrites channels are
  // expected to reach the RAM. Returns 1 time unit after the capture edge.
  task automatic do_sample_s(input bit fixed, input int nwrites);
    logic [15:0] d;
    @(posedge clk); #1;
    smp_s = 1'b1;
    for (int ch = 0; ch < SD; ch++) begin
      d = fixed ? 16'(17 * (ch + 1)) : 16'($urandom);
      ofm_s[ch] = d;
      if (ch < nwrites) q_s.push_back({SA'(ch * SW * SW + exp_pix), d});
    end
    @(posedge clk); #1;
    smp_s = 1'b0;
  endtask

  task automatic do_sample_b(input int pix);
    logic [15:0] d;
    @(posedge clk); #1;
    smp_b = 1'b1;
    for (int ch = 0; ch < BD; ch++) begin
      d = 16'($urandom);
      ofm_b[ch] = d;
      q_b.push_back({BA'(ch * BW * BW + pix), d});
    end
    @(posedge clk); #1;
    smp_b = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; en_s = 1'b1; smp_s = 1'b0; en_b = 1'b1; smp_b = 1'b0;
    for (int ch = 0; ch < SD; ch++) ofm_s[ch] = 16'hABCD;
    for (int ch = 0; ch < BD; ch++) ofm_b[ch] = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      smp_s = ~smp_s; smp_b = ~smp_b;
      @(negedge clk);
      n_cmp++;
      if ({we_s, busy_s, ovf_s, fb_s, addr_s, wd_s} !== '0) begin
        n_bad++;
        $display("FAIL reset_small: we=%b busy=%b ovf=%b fb=%b addr=%0d wd=%h required all 0",
                 we_s, busy_s, ovf_s, fb_s, addr_s, wd_s);
      end
      n_cmp++;
      if ({we_b, busy_b, ovf_b, fb_b, addr_b, wd_b} !== '0) begin
        n_bad++;
        $display("FAIL reset_big: we=%b busy=%b ovf=%b fb=%b addr=%0d wd=%h required all 0",
                 we_b, busy_b, ovf_b, fb_b, addr_b, wd_b);
      end
    end
    @(posedge clk); #1;
    smp_s = 1'b0; smp_b = 1'b0; en_b = 1'b0;
  endtask

  task automatic test_single_pixel;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_pix = 0;
    do_sample_s(1'b1, 4);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy_s !== (i <= 4) || we_s !== (i <= 4)) begin
        n_bad++;
        $display("FAIL single_busy cycle %0d: busy=%b we=%b required %b", i, busy_s, we_s, i <= 4);
      end
    end
    n_cmp++;
    if (q_s.size() != 0) begin
      n_bad++;
      $display("FAIL single_drain: pending=%0d required 0", q_s.size());
    end
  endtask

  task automatic test_overflow;
    exp_pix = 1;
    do_sample_s(1'b0, 4);
    do_sample_s(1'b0, 0);
    @(negedge clk);
    n_cmp++;
    if (ovf_s !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: overflow=%b required 1", ovf_s);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ovf_s !== 1'b1 || q_s.size() != 0) begin
      n_bad++;
      $display("FAIL overflow_sticky: overflow=%b pending=%0d required 1/0", ovf_s, q_s.size());
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ovf_s !== 1'b0) begin
      n_bad++;
      $display("FAIL overflow_clear: overflow=%b required 0", ovf_s);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_full_layer;
    int bad_addr;
    for (int a = 0; a < 64; a++) wcount[a] = 0;
    fb_cnt = 0;
    repeat (2) @(posedge clk);
    for (int p = 0; p < SW * SW; p++) begin
      exp_pix = p;
      do_sample_s(1'b0, 4);
      repeat (8) @(posedge clk);
    end
    n_cmp++;
    if (q_s.size() != 0 || fb_cnt != 1) begin
      n_bad++;
      $display("FAIL full_layer: pending=%0d feedbacks=%0d required 0/1", q_s.size(), fb_cnt);
    end
    bad_addr = 0;
    for (int a = 0; a < 64; a++) if (wcount[a] != 1) bad_addr++;
    n_cmp++;
    if (bad_addr != 0) begin
      n_bad++;
      $display("FAIL full_coverage: addresses not written once=%0d required 0", bad_addr);
    end
    // a sample after the layer is complete is harmless
    do_sample_s(1'b0, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ovf_s !== 1'b0 || fb_cnt != 1 || q_s.size() != 0) begin
      n_bad++;
      $display("FAIL done_sample: overflow=%b feedbacks=%0d required 0/1", ovf_s, fb_cnt);
    end
    @(posedge clk); #1;
    en_s = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_abort;
    int fb_before;
    fb_before = fb_cnt;
    @(posedge clk); #1;
    en_s = 1'b1;
    repeat (2) @(posedge clk);
    for (int p = 0; p < 3; p++) begin
      exp_pix = p;
      do_sample_s(1'b0, 4);
      repeat (8) @(posedge clk);
    end
    exp_pix = 3;
    do_sample_s(1'b0, 2);
    @(posedge clk);
    @(posedge clk); #1;
    en_s = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (we_s !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_we_now: we=%b required 0", we_s);
    end
    @(negedge clk);
    n_cmp++;
    if (we_s !== 1'b0 || busy_s !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle: we=%b busy=%b required 0/0", we_s, busy_s);
    end
    repeat (5) @(posedge clk);
    n_cmp++;
    if (fb_cnt != fb_before || q_s.size() != 0) begin
      n_bad++;
      $display("FAIL abort_nofb: feedbacks=%0d pending=%0d required %0d/0", fb_cnt, q_s.size(), fb_before);
    end
    @(posedge clk); #1;
    en_s = 1'b1;
    repeat (2) @(posedge clk);
    exp_pix = 0;
    do_sample_s(1'b0, 4);
    repeat (8) @(posedge clk);
    n_cmp++;
    if (q_s.size() != 0) begin
      n_bad++;
      $display("FAIL abort_restart: pending=%0d required 0", q_s.size());
    end
  endtask

  task automatic test_async_reset;
    exp_pix = 1;
    do_sample_s(1'b0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (we_s !== 1'b0 || busy_s !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: we=%b busy=%b required 0/0", we_s, busy_s);
    end
    repeat (3) @(posedge clk);
    #1;
    en_s = 1'b0;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    n_cmp++;
    if (q_s.size() != 0) begin
      n_bad++;
      $display("FAIL async_reset_drain: pending=%0d required 0", q_s.size());
    end
  endtask

  task automatic test_defaults;
    fb_b_cnt = 0;
    @(posedge clk); #1;
    en_b = 1'b1;
    repeat (2) @(posedge clk);
    for (int p = 0; p < BW * BW; p++) begin
      do_sample_b(p);
      repeat (38) @(posedge clk);
    end
    n_cmp++;
    if (q_b.size() != 0 || fb_b_cnt != 1) begin
      n_bad++;
      $display("FAIL defaults_layer: pending=%0d feedbacks=%0d required 0/1", q_b.size(), fb_b_cnt);
    end
    n_cmp++;
    if (last_addr_b !== 15'd32767) begin
      n_bad++;
      $display("FAIL defaults_last_addr: last=%0d required 32767", last_addr_b);
    end
    @(posedge clk); #1;
    en_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pixel();
    test_overflow();
    test_full_layer();
    test_abort();
    test_async_reset();
    test_defaults();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
